regfile_writeback: RTL and testbench

Write-side front end of the CPU register file. Merges single-cycle ALU results and long-latency load/multiply results, buffering the latter, and drives the register file's single write port (`waddr`/`wdata`/`wren`) with at most one write per cycle. Keeps a 32-bit pending-write scoreboard for the issue stage and forwards not-yet-written values to the decode-stage read ports.

---
 rtl/wb_pkg.sv | 9 +
 rtl/wb_fifo.sv | 49 ++++
 rtl/regfile_writeback.sv | 126 ++++++++++++
 tb/tb_regfile_writeback.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the write-entry record for the writeback path
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write entries with storage exposed for bypass search
// Ports: clk/rst_n; i_push/i_din write side; i_pop/o_head read side; o_full/o_empty status;
//        o_entries/o_valid/o_rptr expose raw storage, occupied-slot mask and head slot.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  wb_entry_t                  i_din,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output wb_entry_t                  o_head,
  output wb_entry_t                  o_entries [DEPTH],
  output logic [DEPTH-1:0]           o_valid,
  output logic [$clog2(DEPTH)-1:0]   o_rptr
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wptr, r_rptr;
  logic [AW:0] w_count;
  wb_entry_t   r_mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end
  assign w_count   = r_wptr - r_rptr;
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty   = r_wptr == r_rptr;
  assign o_head    = r_mem[r_rptr[AW-1:0]];
  assign o_entries = r_mem;
  assign o_rptr    = r_rptr[AW-1:0];
  // a slot is occupied when its distance from the head is below the occupancy
  always_comb begin
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++)
      o_valid[i] = {1'b0, AW'(i) - r_rptr[AW-1:0]} < w_count;
  end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and long-latency results onto the single register-file write port
// Ports: alu_* single-cycle results (ready drops under queue starvation); lsu_* long-latency results
//        into a queue; rsv_* reserve a destination in the busy scoreboard; rf_* registered write
//        port; byp_* decode-stage forwarding of pending values.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_addr,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_addr,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              rsv_valid,
  input  logic [REG_AW-1:0] rsv_addr,
  output logic [31:0]       busy,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              rf_wren,
  input  logic [REG_AW-1:0] byp_raddr0,
  input  logic [REG_AW-1:0] byp_raddr1,
  output logic              byp_hit0,
  output logic              byp_hit1,
  output logic [XLEN-1:0]   byp_data0,
  output logic [XLEN-1:0]   byp_data1
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE + 1);
  logic                           w_full, w_empty, w_starved;
  logic                           w_alu_xfer, w_push, w_pop;
  wb_entry_t                      w_head;
  wb_entry_t                      w_entries [DEPTH];
  logic [DEPTH-1:0]               w_valid;
  logic [AW-1:0]                  w_rptr;
  logic [SW-1:0]                  r_starve;
  logic [31:0]                    r_busy, w_busy_nxt;
  logic [REG_AW-1:0]              r_waddr;
  logic [XLEN-1:0]                r_wdata;
  logic                           r_wren;
  logic [1:0][REG_AW-1:0]         w_raddr;
  logic [1:0]                     w_hit;
  logic [1:0][XLEN-1:0]           w_bdata;
  assign w_starved  = r_starve >= SW'(STARVE);
  assign alu_ready  = !w_starved;
  assign lsu_ready  = !w_full;
  assign w_alu_xfer = alu_valid && alu_ready;
  // writes to x0 are accepted but never reach the queue
  assign w_push     = lsu_valid && lsu_ready && (lsu_addr != '0);
  assign w_pop      = !w_alu_xfer && !w_empty;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_din     ('{addr: lsu_addr, data: lsu_data}),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_rptr    (w_rptr)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
      r_busy   <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_wren   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_pop) r_starve <= '0;
      else if (w_full && !w_starved) r_starve <= r_starve + 1'b1;
      if (w_alu_xfer) begin
        r_waddr <= alu_addr;
        r_wdata <= alu_data;
        r_wren  <= alu_addr != '0;
      end else if (w_pop) begin
        r_waddr <= w_head.addr;
        r_wdata <= w_head.data;
        r_wren  <= 1'b1;
      end else begin
        r_wren  <= 1'b0;
      end
    end
  end
  // reservation is applied after the pop clear so a same-cycle set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.addr] = 1'b0;
    if (rsv_valid) w_busy_nxt[rsv_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end
  assign busy     = r_busy;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign rf_wren  = r_wren;
  assign w_raddr  = {byp_raddr1, byp_raddr0};
  // output register is the lowest priority; queue scanned oldest to newest so the newest match wins
  always_comb begin
    w_hit   = '0;
    w_bdata = '0;
    for (int p = 0; p < 2; p++) begin
      w_hit[p]   = r_wren && (r_waddr == w_raddr[p]);
      w_bdata[p] = r_wdata;
      for (int k = 0; k < DEPTH; k++) begin
        if (w_valid[w_rptr + AW'(k)] && (w_entries[w_rptr + AW'(k)].addr == w_raddr[p])) begin
          w_hit[p]   = 1'b1;
          w_bdata[p] = w_entries[w_rptr + AW'(k)].data;
        end
      end
      if (w_raddr[p] == '0) w_hit[p] = 1'b0;
    end
  end
  assign byp_hit0  = w_hit[0];
  assign byp_hit1  = w_hit[1];
  assign byp_data0 = w_bdata[0];
  assign byp_data1 = w_bdata[1];
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed table, corner sequences and random traffic against a queue-based model
module tb_regfile_writeback;
  import wb_pkg::*;
  localparam int DEPTH  = 4;
  localparam int STARVE = 4;
  logic        clk = 0, rst_n = 0;
  logic        alu_valid = 0, lsu_valid = 0, rsv_valid = 0;
  logic        alu_ready, lsu_ready, rf_wren, byp_hit0, byp_hit1;
  logic [4:0]  alu_addr = 0, lsu_addr = 0, rsv_addr = 0, byp_raddr0 = 0, byp_raddr1 = 0, rf_waddr;
  logic [31:0] alu_data = 0, lsu_data = 0, busy, rf_wdata, byp_data0, byp_data1;
  int          n_cmp = 0, n_err = 0;
  wb_entry_t   mq[$];
  logic [31:0] mbusy, m_wdata;
  logic [4:0]  m_waddr;
  logic        m_wren;
  int          mstarve;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exp_wren;
  } alu_vec_t;
  alu_vec_t tv[4];

  regfile_writeback #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy(busy),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wren(rf_wren),
    .byp_raddr0(byp_raddr0), .byp_raddr1(byp_raddr1),
    .byp_hit0(byp_hit0), .byp_hit1(byp_hit1), .byp_data0(byp_data0), .byp_data1(byp_data1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy   = 0;
    m_wren  = 0;
    m_waddr = 0;
    m_wdata = 0;
    mstarve = 0;
  endtask

  function automatic void mbyp(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 0;
    d = 0;
    if (a != 0) begin
      if (m_wren && m_waddr == a) begin
        h = 1;
        d = m_wdata;
      end
      foreach (mq[i]) if (mq[i].addr == a) begin
        h = 1;
        d = mq[i].data;
      end
    end
  endfunction

  task automatic idle();
    alu_valid = 0;
    lsu_valid = 0;
    rsv_valid = 0;
  endtask

  task automatic tick();
    logic        h, ax, lx, pop, wasfull;
    logic [31:0] d;
    wb_entry_t   e;
    #1;
    chk("alu_ready", 64'(alu_ready), 64'(mstarve < STARVE));
    chk("lsu_ready", 64'(lsu_ready), 64'(mq.size() < DEPTH));
    chk("busy", 64'(busy), 64'(mbusy));
    mbyp(byp_raddr0, h, d);
    chk("byp_hit0", 64'(byp_hit0), 64'(h));
    if (h) chk("byp_data0", 64'(byp_data0), 64'(d));
    mbyp(byp_raddr1, h, d);
    chk("byp_hit1", 64'(byp_hit1), 64'(h));
    if (h) chk("byp_data1", 64'(byp_data1), 64'(d));
    ax      = alu_valid && (mstarve < STARVE);
    lx      = lsu_valid && (mq.size() < DEPTH);
    wasfull = mq.size() == DEPTH;
    pop     = !ax && mq.size() != 0;
    if (ax) begin
      m_wren  = alu_addr != 0;
      m_waddr = alu_addr;
      m_wdata = alu_data;
    end else if (pop) begin
      e       = mq.pop_front();
      m_wren  = 1;
      m_waddr = e.addr;
      m_wdata = e.data;
      mbusy[e.addr] = 0;
    end else m_wren = 0;
    if (rsv_valid && rsv_addr != 0) mbusy[rsv_addr] = 1;
    if (lx && lsu_addr != 0) mq.push_back('{addr: lsu_addr, data: lsu_data});
    mstarve = pop ? 0 : (wasfull && mstarve < STARVE) ? mstarve + 1 : mstarve;
    @(posedge clk);
    #1;
    chk("rf_wren", 64'(rf_wren), 64'(m_wren));
    if (m_wren) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    end
    chk("busy_q", 64'(busy), 64'(mbusy));
    @(negedge clk);
  endtask

  initial begin
    tv[0] = '{5'd5, 32'h1234, 1'b1};
    tv[1] = '{5'd0, 32'hFFFF, 1'b0};
    tv[2] = '{5'd31, 32'hA5A5A5A5, 1'b1};
    tv[3] = '{5'd1, 32'h0, 1'b1};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wren", 64'(rf_wren), 64'(0));
    chk("rst_waddr", 64'(rf_waddr), 64'(0));
    chk("rst_wdata", 64'(rf_wdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_lsu_ready", 64'(lsu_ready), 64'(1));
    chk("rst_alu_ready", 64'(alu_ready), 64'(1));
    rst_n = 1;
    // ALU writes, latency one, forwarded from the output register
    for (int i = 0; i < 4; i++) begin
      alu_valid  = 1;
      alu_addr   = tv[i].addr;
      alu_data   = tv[i].data;
      byp_raddr0 = tv[i].addr;
      tick();
      chk("tv_wren", 64'(rf_wren), 64'(tv[i].exp_wren));
      chk("tv_hit", 64'(byp_hit0), 64'(tv[i].exp_wren));
      if (tv[i].exp_wren) begin
        chk("tv_waddr", 64'(rf_waddr), 64'(tv[i].addr));
        chk("tv_wdata", 64'(rf_wdata), 64'(tv[i].data));
        chk("tv_bdata", 64'(byp_data0), 64'(tv[i].data));
      end
    end
    // reserve x7, long-latency write, drain two cycles after the handshake
    idle();
    rsv_valid = 1;
    rsv_addr  = 7;
    tick();
    chk("rsv7_busy", 64'(busy[7]), 64'(1));
    rsv_valid  = 0;
    lsu_valid  = 1;
    lsu_addr   = 7;
    lsu_data   = 32'hDEAD;
    byp_raddr1 = 7;
    tick();
    lsu_valid = 0;
    chk("x7_nowren", 64'(rf_wren), 64'(0));
    chk("x7_busy", 64'(busy[7]), 64'(1));
    chk("x7_qhit", 64'(byp_hit1), 64'(1));
    chk("x7_qdata", 64'(byp_data1), 64'(32'hDEAD));
    tick();
    chk("x7_wren", 64'(rf_wren), 64'(1));
    chk("x7_waddr", 64'(rf_waddr), 64'(7));
    chk("x7_wdata", 64'(rf_wdata), 64'(32'hDEAD));
    chk("x7_cleared", 64'(busy[7]), 64'(0));
    // x0 from both sources is swallowed
    alu_valid = 1;
    alu_addr  = 0;
    lsu_valid = 1;
    lsu_addr  = 0;
    tick();
    chk("x0_alu_wren", 64'(rf_wren), 64'(0));
    idle();
    tick();
    chk("x0_lsu_wren", 64'(rf_wren), 64'(0));
    // fill the queue under continuous ALU traffic, then starve
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1;
      alu_addr  = 5'(10 + k);
      alu_data  = k;
      lsu_valid = 1;
      lsu_addr  = 5'(20 + k);
      lsu_data  = 100 + k;
      tick();
    end
    lsu_valid = 0;
    chk("full_lsu_ready", 64'(lsu_ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      chk("full_alu_ready", 64'(alu_ready), 64'(1));
      alu_addr = 11;
      alu_data = 32'h50 + k;
      tick();
    end
    chk("starved", 64'(alu_ready), 64'(0));
    tick();
    chk("starve_pop_wren", 64'(rf_wren), 64'(1));
    chk("starve_pop_addr", 64'(rf_waddr), 64'(20));
    chk("starve_alu_back", 64'(alu_ready), 64'(1));
    chk("starve_lsu_back", 64'(lsu_ready), 64'(1));
    idle();
    repeat (4) tick();
    // two queued values for x3: newest forwarded
    alu_valid  = 1;
    alu_addr   = 9;
    rsv_valid  = 1;
    rsv_addr   = 3;
    lsu_valid  = 1;
    lsu_addr   = 3;
    lsu_data   = 1;
    byp_raddr0 = 3;
    tick();
    rsv_valid = 0;
    lsu_data  = 2;
    tick();
    lsu_valid = 0;
    chk("x3_hit", 64'(byp_hit0), 64'(1));
    chk("x3_newest", 64'(byp_data0), 64'(2));
    idle();
    repeat (3) tick();
    // asynchronous reset with work in flight
    alu_valid = 1;
    alu_addr  = 9;
    for (int k = 0; k < 3; k++) begin
      lsu_valid = 1;
      lsu_addr  = 5'(4 + 2 * k);
      lsu_data  = 32'h700 + k;
      rsv_valid = 1;
      rsv_addr  = 5'(4 + 2 * k);
      tick();
    end
    idle();
    chk("pre_rst_busy", 64'(busy != 0), 64'(1));
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_wren", 64'(rf_wren), 64'(0));
    chk("mid_rst_lsu_ready", 64'(lsu_ready), 64'(1));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_nowren", 64'(rf_wren), 64'(0));
    end
    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      alu_valid  = $urandom_range(0, 1);
      alu_addr   = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      lsu_valid  = $urandom_range(0, 1);
      lsu_addr   = 5'($urandom_range(0, 7));
      lsu_data   = $urandom;
      rsv_valid  = $urandom_range(0, 3) == 0;
      rsv_addr   = 5'($urandom_range(0, 7));
      byp_raddr0 = 5'($urandom_range(0, 7));
      byp_raddr1 = 5'($urandom_range(0, 7));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
